// File: rtl/processor_dispatcher.sv
// processor_dispatcher: routes one motion command at a time to the processor channel
// selected by the opcode map, gates its handshakes and registers its step/servo outputs.
module processor_dispatcher #(
    parameter int NUM_PROCS = 2,
    parameter int OP_BITS = 4,
    parameter int STEPPER_X_BITS = 16,
    parameter int STEPPER_Y_BITS = 16,
    parameter logic [NUM_PROCS*OP_BITS-1:0] OP_MAP =
        (NUM_PROCS*OP_BITS)'({OP_BITS'(3), OP_BITS'(2), OP_BITS'(1), OP_BITS'(0)}),
    parameter int TIMEOUT_CYCLES = 0,
    parameter logic SERVO_POS_UP = 1'b0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [OP_BITS-1:0]                  op,
    input  logic                                trigger_in,
    input  logic                                stepper_done_in,
    input  logic [NUM_PROCS*STEPPER_X_BITS-1:0] proc_num_steps_x_in,
    input  logic [NUM_PROCS*STEPPER_Y_BITS-1:0] proc_num_steps_y_in,
    input  logic [NUM_PROCS-1:0]                proc_servo_pos_in,
    input  logic [NUM_PROCS-1:0]                proc_done_in,
    output logic [NUM_PROCS-1:0]                proc_trigger_out,
    output logic [NUM_PROCS-1:0]                proc_stepper_done_out,
    output logic [STEPPER_X_BITS-1:0]           num_steps_x_out,
    output logic [STEPPER_Y_BITS-1:0]           num_steps_y_out,
    output logic                                servo_pos_out,
    output logic                                busy_out,
    output logic                                done_out,
    output logic                                error_out
);
    localparam int CH_BITS = NUM_PROCS > 1 ? $clog2(NUM_PROCS) : 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, BUSY, DONE} state_t;

    state_t state, state_nxt;
    logic [CH_BITS-1:0] ch, ch_hit;
    logic hit, err, ch_done, expired;
    logic [31:0] cnt;

    // Scan from the top so the lowest matching channel index wins on duplicate ops
    always_comb begin
        hit = 1'b0;
        ch_hit = '0;
        for (int i = NUM_PROCS - 1; i >= 0; i--)
            if (OP_MAP[i*OP_BITS +: OP_BITS] == op) begin
                hit = 1'b1;
                ch_hit = CH_BITS'(i);
            end
    end

    assign ch_done = proc_done_in[ch];
    assign expired = TIMEOUT_CYCLES > 0 && cnt == 32'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (trigger_in) state_nxt = hit ? DISPATCH : DONE;
            DISPATCH: state_nxt = BUSY;
            BUSY:     if (ch_done || expired) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
        endcase
    end

    // A done arriving in the expiry cycle takes priority, so no error is flagged then
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch <= '0;
            err <= 1'b0;
            cnt <= '0;
            num_steps_x_out <= '0;
            num_steps_y_out <= '0;
            servo_pos_out <= SERVO_POS_UP;
        end else begin
            if (state == IDLE && trigger_in) begin
                ch <= ch_hit;
                err <= !hit;
            end
            if (state == BUSY && !ch_done && expired) err <= 1'b1;
            cnt <= (state == BUSY) ? cnt + 32'd1 : '0;
            if (state == BUSY) begin
                num_steps_x_out <= proc_num_steps_x_in[ch*STEPPER_X_BITS +: STEPPER_X_BITS];
                num_steps_y_out <= proc_num_steps_y_in[ch*STEPPER_Y_BITS +: STEPPER_Y_BITS];
                servo_pos_out <= proc_servo_pos_in[ch];
            end
        end
    end

    always_comb begin
        proc_trigger_out = (state == DISPATCH) ? NUM_PROCS'(1) << ch : '0;
        proc_stepper_done_out = (state == BUSY && stepper_done_in) ? NUM_PROCS'(1) << ch : '0;
        busy_out = state == DISPATCH || state == BUSY;
        done_out = state == DONE;
        error_out = state == DONE && err;
    end
endmodule

// File: tb/tb_processor_dispatcher.sv
// tb_processor_dispatcher: vector table, directed corner sequences and random
// stimulus checked against a command-age reference model.
module tb_processor_dispatcher;
    localparam int NP = 4, OB = 4, XB = 16, YB = 16, TO = 8;

    logic clk = 1'b0, reset = 1'b0;
    logic [OB-1:0] op = '0;
    logic trigger_in = 1'b0, stepper_done_in = 1'b0;
    logic [NP*XB-1:0] px = '0;
    logic [NP*YB-1:0] py = '0;
    logic [NP-1:0] pservo = '0, pdone = '0;
    logic [NP-1:0] trig_o, sdone_o;
    logic [XB-1:0] x_o;
    logic [YB-1:0] y_o;
    logic servo_o, busy_o, done_o, err_o;

    int checks = 0, fails = 0, cycle = 0;
    int map_op[NP] = '{0, 1, 2, 3};

    // model: age = cycles since acceptance (-1 when no command), pend marks the done cycle
    int age = -1, mch = 0;
    logic pend = 1'b0, perr = 1'b0, ms = 1'b0;
    logic [XB-1:0] mx = '0;
    logic [YB-1:0] my = '0;

    always #5 clk = ~clk;

    processor_dispatcher #(.NUM_PROCS(NP), .OP_BITS(OB), .STEPPER_X_BITS(XB),
                           .STEPPER_Y_BITS(YB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .trigger_in(trigger_in),
        .stepper_done_in(stepper_done_in), .proc_num_steps_x_in(px),
        .proc_num_steps_y_in(py), .proc_servo_pos_in(pservo), .proc_done_in(pdone),
        .proc_trigger_out(trig_o), .proc_stepper_done_out(sdone_o),
        .num_steps_x_out(x_o), .num_steps_y_out(y_o), .servo_pos_out(servo_o),
        .busy_out(busy_o), .done_out(done_o), .error_out(err_o));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    task automatic tick();
        logic [NP-1:0] e_trig, e_sd;
        logic dn;
        int h;
        @(negedge clk);
        e_trig = (age == 1) ? 4'(1) << mch : '0;
        e_sd = (age >= 2 && stepper_done_in) ? 4'(1) << mch : '0;
        chk("trigger", trig_o, e_trig);
        chk("stepper_done", sdone_o, e_sd);
        chk("busy", busy_o, age >= 1);
        chk("done", done_o, pend);
        chk("error", err_o, pend & perr);
        chk("steps_x", x_o, mx);
        chk("steps_y", y_o, my);
        chk("servo", servo_o, ms);
        dn = pdone[mch];
        @(posedge clk);
        if (pend) pend = 1'b0;
        else if (age >= 2) begin
            mx = px[mch*XB +: XB];
            my = py[mch*YB +: YB];
            ms = pservo[mch];
            if (dn || age == TO + 1) begin
                pend = 1'b1;
                perr = !dn;
                age = -1;
            end else age++;
        end else if (age == 1) age = 2;
        else if (trigger_in) begin
            h = -1;
            for (int i = NP - 1; i >= 0; i--) if (int'(op) == map_op[i]) h = i;
            if (h < 0) begin
                pend = 1'b1;
                perr = 1'b1;
            end else begin
                mch = h;
                age = 1;
            end
        end
        #1 cycle++;
    endtask

    typedef struct {
        logic [3:0] op; logic trig; logic [3:0] done; logic sd;
        logic [3:0] e_trig; logic [3:0] e_sd; logic e_busy, e_done, e_err;
        logic [15:0] e_x, e_y; logic e_servo;
    } vec_t;
    vec_t vt[16];

    initial begin
        int k;
        logic [3:0] q[$];
        vt = '{
            '{4'h1, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0},
            '{4'h1, 1'b0, 4'h0, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0},
            '{4'h0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0},
            '{4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h4, 16'hFFFD, 1'b0},
            '{4'h0, 1'b0, 4'h1, 1'b1, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 16'h4, 16'hFFFD, 1'b0},
            '{4'h0, 1'b0, 4'h2, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h4, 16'hFFFD, 1'b0},
            '{4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h4, 16'hFFFD, 1'b0},
            '{4'h2, 1'b1, 4'h2, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h4, 16'hFFFD, 1'b0},
            '{4'h2, 1'b0, 4'h2, 1'b0, 4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 16'h4, 16'hFFFD, 1'b0},
            '{4'h2, 1'b1, 4'h2, 1'b1, 4'h0, 4'h4, 1'b1, 1'b0, 1'b0, 16'h4, 16'hFFFD, 1'b0},
            '{4'h0, 1'b0, 4'h2, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h5, 16'h6, 1'b1},
            '{4'h0, 1'b0, 4'h6, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 16'h5, 16'h6, 1'b1},
            '{4'h0, 1'b0, 4'h2, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 16'h5, 16'h6, 1'b1},
            '{4'hF, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h5, 16'h6, 1'b1},
            '{4'hF, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h5, 16'h6, 1'b1},
            '{4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h5, 16'h6, 1'b1}
        };
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {trig_o, sdone_o, x_o, y_o, servo_o, busy_o, done_o, err_o}, '0);
        reset = 1'b1;
        px = {16'd7, 16'd5, 16'd4, 16'd1};
        py = {16'd8, 16'd6, 16'hFFFD, 16'd2};
        pservo = 4'b0100;

        for (int r = 0; r < 16; r++) begin
            op = vt[r].op;
            trigger_in = vt[r].trig;
            pdone = vt[r].done;
            stepper_done_in = vt[r].sd;
            #1;
            chk("vec_trigger", trig_o, vt[r].e_trig);
            chk("vec_stepper_done", sdone_o, vt[r].e_sd);
            chk("vec_busy", busy_o, vt[r].e_busy);
            chk("vec_done", done_o, vt[r].e_done);
            chk("vec_error", err_o, vt[r].e_err);
            chk("vec_steps", {x_o, y_o}, {vt[r].e_x, vt[r].e_y});
            chk("vec_servo", servo_o, vt[r].e_servo);
            tick();
        end
        pdone = '0;
        stepper_done_in = 1'b0;

        // timeout with no done: done_out 10 cycles after acceptance
        op = 4'h0;
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        k = 1;
        while (!done_o && k < 20) begin
            tick();
            k++;
        end
        chk("timeout_cycle", k, 10);
        chk("timeout_error", err_o, 1'b1);
        tick();

        // done on the 8th BUSY cycle beats the timeout
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        repeat (8) tick();
        pdone = 4'b0001;
        tick();
        pdone = '0;
        chk("done_vs_timeout_done", done_o, 1'b1);
        chk("done_vs_timeout_error", err_o, 1'b0);
        tick();

        // trigger held through BUSY and DONE
        op = 4'h1;
        trigger_in = 1'b1;
        tick();
        for (int j = 1; j <= 8; j++) begin
            pdone = (j == 4) ? 4'b0010 : 4'b0000;
            if (trig_o != '0) q.push_back(4'(j));
            tick();
        end
        chk("held_trigger_pulses", q.size(), 2);
        if (q.size() == 2) chk("held_trigger_reaccept", q[1], 4'd7);
        trigger_in = 1'b0;
        pdone = 4'b0010;
        repeat (3) tick();
        pdone = '0;

        // asynchronous reset in BUSY
        op = 4'h2;
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        stepper_done_in = 1'b1;
        repeat (3) tick();
        chk("pre_reset_busy", busy_o, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {trig_o, sdone_o, x_o, y_o, busy_o, done_o, err_o}, '0);
        chk("async_reset_servo", servo_o, 1'b0);
        age = -1; pend = 1'b0; mx = '0; my = '0; ms = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_no_done", done_o, 1'b0);
        reset = 1'b1;
        stepper_done_in = 1'b0;
        cycle++;
        op = 4'h1;
        trigger_in = 1'b1;
        tick();
        trigger_in = 1'b0;
        chk("redispatch", trig_o, 4'b0010);
        repeat (2) tick();
        pdone = 4'b0010;
        tick();
        pdone = '0;
        repeat (2) tick();

        for (int n = 0; n < 600; n++) begin
            op = ($urandom_range(9) == 0) ? 4'hF : 4'($urandom_range(4));
            trigger_in = $urandom_range(3) == 0;
            stepper_done_in = 1'($urandom_range(1));
            pdone = 4'($urandom) & 4'($urandom) & 4'($urandom);
            px = {$urandom, $urandom};
            py = {$urandom, $urandom};
            pservo = 4'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
